// File: rtl/alt_aeq_pkg.sv
// Shared constants and types for the AEQ channel adaptation responder.
// Channel width is shared with the AEQ full-ADCE controller.
package alt_aeq_pkg;

    localparam int unsigned LCH_W              = 10;
    localparam int unsigned DEF_SETTLE_CYCLES  = 64;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 65536;
    localparam int unsigned DEF_CNT_W          = 17;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SETTLE     = 3'd1;
    localparam logic [2:0] ST_RUN        = 3'd2;
    localparam logic [2:0] ST_CLEAR      = 3'd3;
    localparam logic [2:0] ST_CLEAR_WAIT = 3'd4;
    localparam logic [2:0] ST_RELEASE    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_SETTLE     = ST_SETTLE,
        S_RUN        = ST_RUN,
        S_CLEAR      = ST_CLEAR,
        S_CLEAR_WAIT = ST_CLEAR_WAIT,
        S_RELEASE    = ST_RELEASE
    } adapt_state_e;

    typedef struct packed {
        logic lf_not_found;
        logic hf_not_found;
        logic conv_error;
    } adapt_result_t;

endpackage

// File: rtl/alt_aeq_ch_adapt_if.sv
// Controller handshake and transceiver ADCE pins of one adaptation channel.
// master = controller/engine side, slave = channel responder.
interface alt_aeq_ch_adapt_if;
    import alt_aeq_pkg::*;

    logic             i_ch_start;
    logic             i_ch_disable;
    logic [LCH_W-1:0] i_logical_ch;
    logic             o_ch_busy0q;
    logic             o_ch_lf_not_found0q;
    logic             o_ch_hf_not_found0q;
    logic             o_ch_conv_error0q;
    logic [LCH_W-1:0] o_adce_ch0q;
    logic             o_adce_run0q;
    logic             o_adce_clr0q;
    logic             i_adce_done;
    logic             i_adce_lf_limit;
    logic             i_adce_hf_limit;

    modport master (
        output i_ch_start, i_ch_disable, i_logical_ch,
        output i_adce_done, i_adce_lf_limit, i_adce_hf_limit,
        input  o_ch_busy0q, o_ch_lf_not_found0q, o_ch_hf_not_found0q,
        input  o_ch_conv_error0q, o_adce_ch0q, o_adce_run0q, o_adce_clr0q
    );

    modport slave (
        input  i_ch_start, i_ch_disable, i_logical_ch,
        input  i_adce_done, i_adce_lf_limit, i_adce_hf_limit,
        output o_ch_busy0q, o_ch_lf_not_found0q, o_ch_hf_not_found0q,
        output o_ch_conv_error0q, o_adce_ch0q, o_adce_run0q, o_adce_clr0q
    );

endinterface

// File: rtl/alt_aeq_adapt_timer.sv
// Loadable (to zero) saturating up-counter with terminal-count compare,
// shared by the settle and run phases.
module alt_aeq_adapt_timer #(
    parameter int unsigned CNT_W = 17
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_tc,
    output logic             o_tc_hit_c
);

    logic [CNT_W-1:0] cnt;

    // Saturate at all-ones so a long run can never wrap back to an early count
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= '0;
        end else if (i_en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign o_tc_hit_c = (cnt == i_tc);

endmodule

// File: rtl/alt_aeq_ch_adapt.sv
// Per-channel ADCE adaptation responder: start/disable handshake, settle,
// timed engine run and result return. Optional ALT_AEQ_ADAPT_RETRY_EN adds one retry on timeout.
module alt_aeq_ch_adapt
    import alt_aeq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic               i_clock,
    input  logic               i_reset,
    alt_aeq_ch_adapt_if.slave  bus
);

    adapt_state_e     state;
    adapt_result_t    result_q;
    logic [LCH_W-1:0] ch_q;
    logic             busy_q;
    logic             run_q;
    logic             clr_q;
`ifdef ALT_AEQ_ADAPT_RETRY_EN
    logic             retry_used_q;
`endif

    logic [CNT_W-1:0] cnt_tc_c;
    logic             cnt_en_c;
    logic             cnt_load_c;
    logic             cnt_hit_c;

    // Terminal count per phase; CLEAR_WAIT holds busy for two cycles after the clear pulse
    always_comb begin
        cnt_tc_c = CNT_W'(1);
        cnt_en_c = 1'b0;
        case (state)
            S_SETTLE: begin
                cnt_tc_c = CNT_W'(SETTLE_CYCLES - 32'd1);
                cnt_en_c = 1'b1;
            end
            S_RUN: begin
                cnt_tc_c = CNT_W'(TIMEOUT_CYCLES - 32'd1);
                cnt_en_c = 1'b1;
            end
            S_CLEAR_WAIT: begin
                cnt_en_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign cnt_load_c = !cnt_en_c || cnt_hit_c;

    alt_aeq_adapt_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (cnt_load_c),
        .i_en       (cnt_en_c),
        .i_tc       (cnt_tc_c),
        .o_tc_hit_c (cnt_hit_c)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= S_IDLE;
            result_q <= '0;
            ch_q     <= '0;
            busy_q   <= 1'b0;
            run_q    <= 1'b0;
            clr_q    <= 1'b0;
`ifdef ALT_AEQ_ADAPT_RETRY_EN
            retry_used_q <= 1'b0;
`endif
        end else begin
            clr_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_ch_disable || bus.i_ch_start) begin
                        ch_q     <= bus.i_logical_ch;
                        result_q <= '0;
                        busy_q   <= 1'b1;
`ifdef ALT_AEQ_ADAPT_RETRY_EN
                        retry_used_q <= 1'b0;
`endif
                        if (bus.i_ch_disable) begin
                            clr_q <= 1'b1;
                            state <= S_CLEAR;
                        end else begin
                            state <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt_hit_c) begin
                        run_q <= 1'b1;
                        state <= S_RUN;
                    end
                end
                // Done beats a same-cycle timeout
                S_RUN: begin
                    if (bus.i_adce_done) begin
                        result_q <= '{lf_not_found: bus.i_adce_lf_limit,
                                      hf_not_found: bus.i_adce_hf_limit,
                                      conv_error:   1'b0};
                        run_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        state    <= S_RELEASE;
                    end else if (cnt_hit_c) begin
`ifdef ALT_AEQ_ADAPT_RETRY_EN
                        if (!retry_used_q) begin
                            retry_used_q <= 1'b1;
                            run_q        <= 1'b0;
                            clr_q        <= 1'b1;
                            state        <= S_CLEAR;
                        end else
`endif
                        begin
                            result_q <= '{lf_not_found: bus.i_adce_lf_limit,
                                          hf_not_found: bus.i_adce_hf_limit,
                                          conv_error:   1'b1};
                            run_q    <= 1'b0;
                            busy_q   <= 1'b0;
                            state    <= S_RELEASE;
                        end
                    end
                end
                S_CLEAR: begin
`ifdef ALT_AEQ_ADAPT_RETRY_EN
                    state <= retry_used_q ? S_SETTLE : S_CLEAR_WAIT;
`else
                    state <= S_CLEAR_WAIT;
`endif
                end
                S_CLEAR_WAIT: begin
                    if (cnt_hit_c) begin
                        busy_q <= 1'b0;
                        state  <= S_RELEASE;
                    end
                end
                // A request still held from the finished transaction must drop first
                S_RELEASE: begin
                    if (!bus.i_ch_start && !bus.i_ch_disable) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ch_busy0q         = busy_q;
    assign bus.o_ch_lf_not_found0q = result_q.lf_not_found;
    assign bus.o_ch_hf_not_found0q = result_q.hf_not_found;
    assign bus.o_ch_conv_error0q   = result_q.conv_error;
    assign bus.o_adce_ch0q         = ch_q;
    assign bus.o_adce_run0q        = run_q;
    assign bus.o_adce_clr0q        = clr_q;

endmodule

// File: tb/tb_alt_aeq_ch_adapt.sv
// Self-checking bench for alt_aeq_ch_adapt: directed and randomized
// transactions against a cycle-count model of the handshake.
module tb_alt_aeq_ch_adapt;
    import alt_aeq_pkg::*;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 256;
    localparam int BOUND   = 2000;

    logic i_clock = 1'b0;
    logic i_reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    alt_aeq_ch_adapt_if bus ();

    alt_aeq_ch_adapt #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (17)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clock = ~i_clock;

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One request/response transaction; done_at is the run cycle (1-based) in which done is raised, 0 = never
    task automatic txn(input string tag, input logic [9:0] ch, input bit dis,
                       input int done_at, input bit lf, input bit hf, input int hold);
        int busy_n, run_n, clr_n, first_run, steps, bad;
        int attempts, run_exp, clr_exp, busy_exp;
        bit conv_exp, first_ok;
        busy_n = 0; run_n = 0; clr_n = 0; first_run = -1; steps = 0; bad = 0;

        if (dis) begin
            attempts = 0; run_exp = 0; conv_exp = 1'b0; clr_exp = 1; busy_exp = 3;
        end else begin
            first_ok = (done_at > 0) && (done_at <= TIMEOUT);
`ifdef ALT_AEQ_ADAPT_RETRY_EN
            attempts = first_ok ? 1 : 2;
`else
            attempts = 1;
`endif
            conv_exp = !((done_at > 0) && (done_at <= attempts * TIMEOUT));
            run_exp  = conv_exp ? attempts * TIMEOUT : done_at;
            clr_exp  = attempts - 1;
            busy_exp = attempts * SETTLE + run_exp + clr_exp;
        end

        bus.i_logical_ch    = ch;
        bus.i_ch_start      = 1'b1;
        bus.i_ch_disable    = dis;
        bus.i_adce_lf_limit = lf;
        bus.i_adce_hf_limit = hf;
        bus.i_adce_done     = 1'b0;
        step();
        chk({tag, "_busy_latency"}, 32'(bus.o_ch_busy0q), 32'd1);

        while ((bus.o_ch_busy0q === 1'b1) && (steps < BOUND)) begin
            busy_n++;
            if (hold == 0) begin
                bus.i_ch_start   = 1'b0;
                bus.i_ch_disable = 1'b0;
            end
            if (bus.o_adce_run0q === 1'b1) begin
                run_n++;
                if (first_run < 0) first_run = busy_n - 1;
            end
            if (bus.o_adce_clr0q === 1'b1) clr_n++;
            bus.i_adce_done = (bus.o_adce_run0q === 1'b1) && (done_at > 0) && (run_n == done_at);
            step();
            steps++;
        end
        bus.i_adce_done = 1'b0;

        chk({tag, "_bounded"}, 32'(steps < BOUND), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(busy_exp));
        chk({tag, "_run_cycles"}, 32'(run_n), 32'(run_exp));
        chk({tag, "_clr_pulses"}, 32'(clr_n), 32'(clr_exp));
        if (!dis) chk({tag, "_settle"}, 32'(first_run), 32'(SETTLE));
        chk({tag, "_run_at_fall"}, 32'(bus.o_adce_run0q), 32'd0);
        chk({tag, "_lf"}, 32'(bus.o_ch_lf_not_found0q), 32'(dis ? 1'b0 : lf));
        chk({tag, "_hf"}, 32'(bus.o_ch_hf_not_found0q), 32'(dis ? 1'b0 : hf));
        chk({tag, "_conv"}, 32'(bus.o_ch_conv_error0q), 32'(conv_exp));
        chk({tag, "_ch"}, 32'(bus.o_adce_ch0q), 32'(ch));

        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                step();
                if ((bus.o_ch_busy0q !== 1'b0) || (bus.o_adce_run0q !== 1'b0)) bad++;
            end
            chk({tag, "_no_retrigger"}, 32'(bad), 32'd0);
            chk({tag, "_conv_stable"}, 32'(bus.o_ch_conv_error0q), 32'(conv_exp));
        end
        bus.i_ch_start   = 1'b0;
        bus.i_ch_disable = 1'b0;
        step();
    endtask

    initial begin
        int n;
        int steps;
        i_reset             = 1'b1;
        bus.i_ch_start      = 1'b0;
        bus.i_ch_disable    = 1'b0;
        bus.i_logical_ch    = '0;
        bus.i_adce_done     = 1'b0;
        bus.i_adce_lf_limit = 1'b0;
        bus.i_adce_hf_limit = 1'b0;
        step();
        step();
        chk("reset_outputs", 32'({bus.o_ch_busy0q, bus.o_adce_run0q, bus.o_adce_clr0q,
                                  bus.o_ch_lf_not_found0q, bus.o_ch_hf_not_found0q,
                                  bus.o_ch_conv_error0q, bus.o_adce_ch0q}), 32'd0);
        i_reset = 1'b0;
        step();

        txn("converge", 10'd3, 1'b0, 100, 1'b1, 1'b0, 0);
        txn("timeout", 10'd17, 1'b0, 0, 1'b0, 1'b1, 0);
        txn("disable", 10'd512, 1'b1, 50, 1'b1, 1'b1, 0);
        txn("held_start", 10'd99, 1'b0, 30, 1'b0, 1'b0, 20);
        txn("after_hold", 10'd100, 1'b0, 5, 1'b1, 1'b1, 0);
        txn("done_at_tc", 10'd5, 1'b0, TIMEOUT, 1'b0, 1'b1, 0);
`ifdef ALT_AEQ_ADAPT_RETRY_EN
        txn("retry", 10'd7, 1'b0, TIMEOUT + 10, 1'b0, 1'b1, 0);
`endif

        // Reset in RUN cycle 50
        bus.i_logical_ch = 10'h2a5;
        bus.i_ch_start   = 1'b1;
        step();
        bus.i_ch_start = 1'b0;
        n = 0;
        steps = 0;
        while ((n < 50) && (steps < BOUND)) begin
            if (bus.o_adce_run0q === 1'b1) n++;
            if (n < 50) step();
            steps++;
        end
        chk("rst_reached_run50", 32'(n), 32'd50);
        i_reset = 1'b1;
        step();
        chk("rst_outputs_zero", 32'({bus.o_ch_busy0q, bus.o_adce_run0q, bus.o_adce_clr0q,
                                     bus.o_ch_lf_not_found0q, bus.o_ch_hf_not_found0q,
                                     bus.o_ch_conv_error0q, bus.o_adce_ch0q}), 32'd0);
        i_reset = 1'b0;
        step();
        txn("post_reset", 10'd321, 1'b0, 12, 1'b1, 1'b0, 0);

        for (int k = 0; k < 8; k++) begin
            logic [9:0] ch;
            bit         dis;
            int         done_at;
            ch      = 10'($urandom_range(0, 1023));
            dis     = ($urandom_range(0, 3) == 0);
            done_at = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 300));
            txn($sformatf("rand%0d", k), ch, dis, done_at,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
